ed25519_encode: RTL
===================

// Module: ed25519_encode
// PURPOSE
// - Downstream of the ed25519 scalar-multiply core; consumes extended point (X,Y,Z,T) on its done.
// - Computes Zinv = Z^(q-2) mod q (Fermat, constant time), then affine x = X*Zinv, y = Y*Zinv.
// - Emits RFC 8032 compressed 256-bit encoding {x[0], y[254:0]}.
// - Single shared bit-serial modular multiplier; no DSP inference required.
// PARAMETERS
// - B     257      input coordinate width; matches the core's x3/y3/z3/t3
// - N     255      field width
// - Q     2^255-19 field prime; decimal
//                  57896044618658097711785492504343953926634992332820282019728792003956564819949
// PORTS
// - clk     in   1    clock, rising edge
// - rst     in   1    asynchronous, active-high reset
// - start   in   1    load request; sampled only in IDLE/DONE
// - x,y,z,t in   B    extended coordinates; bits [B-1:N] ignored
// - busy    out  1    high from the cycle after start until done
// - done    out  1    level; high from completion until next accepted start
// - xa,ya   out  N    affine coordinates in [0,q)
// - enc     out  N+1  {xa[0], ya}
// - err     out  1    Z == 0 mod q (no inverse); xa=ya=enc=0
// - valid   out  1    extended-coordinate check result (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE; busy=done=err=0; valid=1; xa=ya=enc=0. Async assert; release sync to clk.
// - FSM states: IDLE -> LOAD -> INV -> MULX -> MULY [-> CHK1 -> CHK2] -> FIN -> DONE.
// - LOAD (1 cycle): latch v[N-1:0] per coordinate; subtract Q once if the value is >= Q.
// - Multiplier: interleaved MSB-first. P=0; per bit of b: P=2P mod q, then P+=a mod q if the bit is set.
//   - Each step uses two conditional subtracts on (N+2)-bit intermediates.
//   - One mult = 1 setup + 255 step cycles = 256 cycles.
// - INV: acc=1; for e=254..0: acc=acc^2, then tmp=acc*Z; acc=tmp iff bit e of (Q-2) is set.
//   - The multiply always executes (constant time): 510 mults.
// - MULX/MULY: one mult each.
// - FIN: register xa/ya/enc/err/valid; enter DONE with done=1, busy=0.
// - Latency from start sampled high to done high: 1 + 512*256 + 1 = 131074 cycles.
// - start while busy is ignored; no queuing, inputs not re-sampled.
// - start in DONE: accepted; done drops the next cycle; outputs hold old values until FIN.
// - Z==0 or Z==Q: the inverse evaluates to 0; err=1 and outputs are forced to 0.
// - Reset mid-operation aborts immediately to the reset values; no partial outputs.
// - All arithmetic is unsigned; inputs are treated as unsigned despite the upstream signed nets.
// CONFIGURATION
// - ED25519_EXT_CHECK_EN defined:
//   - CHK1 computes X*Y and CHK2 computes Z*T, +512 cycles (latency 131586).
//   - valid = (X*Y == Z*T mod q); t is used.
// - ED25519_EXT_CHECK_EN undefined:
//   - CHK states are absent; t is unused; valid is tied 1; latency 131074.
// TESTING
// - Base point, z=1:
//   x=15112221349535400772501151409588531511454012693041857206046113283949847762202,
//   y=46316835694926478169428394003475163141307993866256225615783033603165251855960
//   -> xa=x, ya=y, enc=y (x even), err=0, done at cycle 131074.
// - Same point scaled by z=Q-1 (x'=Q-x, y'=Q-y, t unchanged) -> identical xa/ya/enc.
// - Identity (0,1,1,0) -> xa=0, ya=1, enc=1, err=0, valid=1.
// - z=0 (x=5, y=7) -> err=1, xa=ya=enc=0. Then z=Q -> err=1 again.
// - start pulsed at cycles 10 and 5000 of a run -> single completion at 131074 with the first inputs.
//   Also: rst at cycle 70000 -> busy=done=0 next edge; a fresh start completes normally.
// - With ED25519_EXT_CHECK_EN: base point, t=x*y mod q -> valid=1; t=t+1 -> valid=0; done at 131586.

Source files
------------

// File: rtl/ed25519_encode_if.sv
// Bus bundle for ed25519_encode: load request and extended point in, affine/encoded point out.
interface ed25519_encode_if #(
    parameter int B = 257,
    parameter int N = 255
);
    // start is sampled only while idle or done; busy covers every cycle from the one after an
    // accepted start until done rises; done is a level that holds, with the results, until the
    // next accepted start. There is no backpressure and start while busy is dropped.
    logic         start;
    logic [B-1:0] x;
    logic [B-1:0] y;
    logic [B-1:0] z;
    logic [B-1:0] t;
    logic         busy;
    logic         done;
    logic [N-1:0] xa;
    logic [N-1:0] ya;
    logic [N:0]   enc;
    logic         err;
    logic         valid;
    logic [3:0]   dbg_state;

    modport master (
        output start, x, y, z, t,
        input  busy, done, xa, ya, enc, err, valid, dbg_state
    );

    modport slave (
        input  start, x, y, z, t,
        output busy, done, xa, ya, enc, err, valid, dbg_state
    );
endinterface

// File: rtl/ed25519_encode.sv
// Extended (X,Y,Z,T) to RFC 8032 compressed point via Fermat inversion on one bit-serial multiplier.
// Optional extended-coordinate consistency check (X*Y == Z*T) enabled by ED25519_EXT_CHECK_EN.
module ed25519_encode #(
    parameter int B = 257,
    parameter int N = 255
) (
    input  logic            clk,
    input  logic            rst,
    ed25519_encode_if.slave bus
);
    localparam logic [N-1:0] Q   = 255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
    localparam logic [N-1:0] QM2 = 255'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFEB;
    localparam logic [7:0]   TOP = 8'(N - 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LOAD = 4'd1,
        S_INV  = 4'd2,
        S_MULX = 4'd3,
        S_MULY = 4'd4,
`ifdef ED25519_EXT_CHECK_EN
        S_CHK1 = 4'd5,
        S_CHK2 = 4'd6,
`endif
        S_FIN  = 4'd7,
        S_DONE = 4'd8
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [N-1:0] acc_q, acc_d, xr_q, xr_d, yr_q, yr_d;
    logic [N-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
    logic [N-1:0] xa_q, xa_d, ya_q, ya_d;
    logic [7:0]   cnt_q, cnt_d, e_q, e_d;
    logic         sq_q, sq_d, setup_q, setup_d;
    logic         err_q, err_d, valid_q, valid_d;
`ifdef ED25519_EXT_CHECK_EN
    logic [N-1:0] t_q, t_d, xy_q, xy_d;
    logic         chk_q, chk_d;
`endif

    logic         mul_active, mul_done;
    logic [N-1:0] op_a, op_b, p_step;
    logic [N+1:0] dbl, dbl_r, sum, sum_r;

    function automatic logic [N-1:0] reduce_q(input logic [N-1:0] v);
        return (v >= Q) ? v - Q : v;
    endfunction

    // One interleaved step: P = 2P mod q, then P = P + a mod q when the current MSB of b is set.
    always_comb begin
        dbl    = {1'b0, p_q, 1'b0};
        dbl_r  = (dbl >= {2'b00, Q}) ? dbl - {2'b00, Q} : dbl;
        sum    = dbl_r + (b_q[N-1] ? {2'b00, a_q} : {(N+2){1'b0}});
        sum_r  = (sum >= {2'b00, Q}) ? sum - {2'b00, Q} : sum;
        p_step = sum_r[N-1:0];
    end

    always_comb begin
        op_a       = acc_q;
        op_b       = acc_q;
        mul_active = 1'b1;
        case (state_q)
            S_INV:   op_b = sq_q ? acc_q : z_q;
            S_MULX:  op_a = x_q;
            S_MULY:  op_a = y_q;
`ifdef ED25519_EXT_CHECK_EN
            S_CHK1: begin
                op_a = x_q;
                op_b = y_q;
            end
            S_CHK2: begin
                op_a = z_q;
                op_b = t_q;
            end
`endif
            default: mul_active = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        acc_d    = acc_q;
        xr_d     = xr_q;
        yr_d     = yr_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        xa_d     = xa_q;
        ya_d     = ya_q;
        cnt_d    = cnt_q;
        e_d      = e_q;
        sq_d     = sq_q;
        setup_d  = setup_q;
        err_d    = err_q;
        valid_d  = valid_q;
        mul_done = 1'b0;
`ifdef ED25519_EXT_CHECK_EN
        t_d      = t_q;
        xy_d     = xy_q;
        chk_d    = chk_q;
`endif

        if (mul_active) begin
            if (setup_q) begin
                a_d     = op_a;
                b_d     = op_b;
                p_d     = '0;
                cnt_d   = TOP;
                setup_d = 1'b0;
            end else begin
                p_d   = p_step;
                b_d   = {b_q[N-2:0], 1'b0};
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd0) begin
                    mul_done = 1'b1;
                    setup_d  = 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    x_d     = bus.x[N-1:0];
                    y_d     = bus.y[N-1:0];
                    z_d     = bus.z[N-1:0];
`ifdef ED25519_EXT_CHECK_EN
                    t_d     = bus.t[N-1:0];
`endif
                end
            end
            S_LOAD: begin
                x_d     = reduce_q(x_q);
                y_d     = reduce_q(y_q);
                z_d     = reduce_q(z_q);
`ifdef ED25519_EXT_CHECK_EN
                t_d     = reduce_q(t_q);
`endif
                acc_d   = ONE;
                e_d     = TOP;
                sq_d    = 1'b1;
                setup_d = 1'b1;
                state_d = S_INV;
            end
            // Square then multiply by Z every exponent bit; keep the product only where q-2 has a 1.
            S_INV: begin
                if (mul_done) begin
                    if (sq_q) begin
                        acc_d = p_step;
                        sq_d  = 1'b0;
                    end else begin
                        if (QM2[e_q]) acc_d = p_step;
                        sq_d = 1'b1;
                        if (e_q == 8'd0) state_d = S_MULX;
                        else             e_d     = e_q - 8'd1;
                    end
                end
            end
            S_MULX: begin
                if (mul_done) begin
                    xr_d    = p_step;
                    state_d = S_MULY;
                end
            end
            S_MULY: begin
                if (mul_done) begin
                    yr_d    = p_step;
`ifdef ED25519_EXT_CHECK_EN
                    state_d = S_CHK1;
`else
                    state_d = S_FIN;
`endif
                end
            end
`ifdef ED25519_EXT_CHECK_EN
            S_CHK1: begin
                if (mul_done) begin
                    xy_d    = p_step;
                    state_d = S_CHK2;
                end
            end
            S_CHK2: begin
                if (mul_done) begin
                    chk_d   = (p_step == xy_q);
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                err_d   = (z_q == '0);
                xa_d    = err_d ? '0 : xr_q;
                ya_d    = err_d ? '0 : yr_q;
`ifdef ED25519_EXT_CHECK_EN
                valid_d = chk_q;
`else
                valid_d = 1'b1;
`endif
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            acc_q   <= '0;
            xr_q    <= '0;
            yr_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            xa_q    <= '0;
            ya_q    <= '0;
            cnt_q   <= '0;
            e_q     <= '0;
            sq_q    <= 1'b0;
            setup_q <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
`ifdef ED25519_EXT_CHECK_EN
            t_q     <= '0;
            xy_q    <= '0;
            chk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            acc_q   <= acc_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            xa_q    <= xa_d;
            ya_q    <= ya_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            sq_q    <= sq_d;
            setup_q <= setup_d;
            err_q   <= err_d;
            valid_q <= valid_d;
`ifdef ED25519_EXT_CHECK_EN
            t_q     <= t_d;
            xy_q    <= xy_d;
            chk_q   <= chk_d;
`endif
        end
    end

    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.xa        = xa_q;
    assign bus.ya        = ya_q;
    assign bus.enc       = {xa_q[0], ya_q};
    assign bus.err       = err_q;
    assign bus.valid     = valid_q;
    assign bus.dbg_state = state_q;

    // Upper input bits are sign/carry spill from the upstream core and carry no information.
    logic unused_bits;
`ifdef ED25519_EXT_CHECK_EN
    assign unused_bits = ^{bus.x[B-1:N], bus.y[B-1:N], bus.z[B-1:N], bus.t[B-1:N], sum_r[N+1:N]};
`else
    assign unused_bits = ^{bus.x[B-1:N], bus.y[B-1:N], bus.z[B-1:N], bus.t, sum_r[N+1:N]};
`endif
endmodule
